cardinal_nic: RTL

CARDINAL_NIC -- requirements
Module: cardinal_nic

---
 rtl/cardinal_nic.sv | 103 ++++++++++
 1 files changed

// File: rtl/cardinal_nic.sv
// rtl/cardinal_nic.sv - single-slot network interface between a processor and a router (optional macro CARDINAL_NIC_POLARITY_EN)
module cardinal_nic (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:1]  addr,
  input  logic [0:63] d_in,
  output logic [0:63] d_out,
  input  logic        nicEn,
  input  logic        nicWrEn,
  input  logic        net_si,
  output logic        net_ri,
  input  logic [0:63] net_di,
  output logic        net_so,
  input  logic        net_ro,
  output logic [0:63] net_do,
  input  logic        net_polarity
);

  localparam logic [0:1] ADDR_IN_BUF     = 2'b00;
  localparam logic [0:1] ADDR_IN_STATUS  = 2'b01;
  localparam logic [0:1] ADDR_OUT_BUF    = 2'b10;
  localparam logic [0:1] ADDR_OUT_STATUS = 2'b11;

  logic [0:63] in_buf_q, in_buf_d;
  logic [0:63] out_buf_q, out_buf_d;
  logic        in_full_q, in_full_d;
  logic        out_full_q, out_full_d;

  logic proc_rd;
  logic proc_wr;
  logic pol_ok;

  assign proc_rd = nicEn & ~nicWrEn;
  assign proc_wr = nicEn & nicWrEn;

`ifdef CARDINAL_NIC_POLARITY_EN
  // Bit 0 of the packet selects the virtual channel; only send on the matching router phase.
  assign pol_ok = (out_buf_q[0] == net_polarity);
`else
  // Polarity is not used in this build; the tie-off keeps the port referenced.
  logic unused_polarity;
  assign unused_polarity = net_polarity;
  assign pol_ok          = 1'b1;
`endif

  assign net_ri = ~in_full_q;
  assign net_so = out_full_q & net_ro & pol_ok;
  assign net_do = out_buf_q;

  // Processor read mux; status words carry the flag in the last bit.
  always_comb begin
    d_out = '0;
    if (proc_rd) begin
      case (addr)
        ADDR_IN_BUF:     d_out = in_buf_q;
        ADDR_IN_STATUS:  d_out = {63'b0, in_full_q};
        ADDR_OUT_BUF:    d_out = out_buf_q;
        ADDR_OUT_STATUS: d_out = {63'b0, out_full_q};
        default:         d_out = '0;
      endcase
    end
  end

  // Next-state for both slots; decisions use only pre-edge flag values.
  always_comb begin
    in_buf_d   = in_buf_q;
    in_full_d  = in_full_q;
    out_buf_d  = out_buf_q;
    out_full_d = out_full_q;

    // Inbound: a capture can only happen while empty, so it never races the read-clear.
    if (net_si && !in_full_q) begin
      in_buf_d  = net_di;
      in_full_d = 1'b1;
    end else if (proc_rd && (addr == ADDR_IN_BUF)) begin
      in_full_d = 1'b0;
    end

    // Outbound: a load needs the slot empty and a send needs it full, so they are exclusive.
    if (proc_wr && (addr == ADDR_OUT_BUF) && !out_full_q) begin
      out_buf_d  = d_in;
      out_full_d = 1'b1;
    end else if (net_so) begin
      out_full_d = 1'b0;
    end
  end

  // State registers; reset discards both slots immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_buf_q   <= '0;
      in_full_q  <= 1'b0;
      out_buf_q  <= '0;
      out_full_q <= 1'b0;
    end else begin
      in_buf_q   <= in_buf_d;
      in_full_q  <= in_full_d;
      out_buf_q  <= out_buf_d;
      out_full_q <= out_full_d;
    end
  end

endmodule
